// File: rtl/lw_sha_padder.sv
// lw_sha_padder: appends FIPS 180-4 padding to a 32-bit message word stream and feeds the lightweight SHA-256/224 core.
// Optional abort path is enabled by defining LW_SHA_PADDER_ABORT_EN.
module lw_sha_padder #(
  parameter int LEN_W = 32
) (
  input  logic        clk_i,
  input  logic        aresetn_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  input  logic        in_last_i,
  input  logic [2:0]  in_nbytes_i,
  input  logic        in_opcode_i,
  output logic        in_ready_o,
  output logic        core_start_o,
  output logic        core_data_valid_o,
  output logic        core_last_o,
  output logic [31:0] core_data_o,
  output logic        core_opcode_o,
  input  logic        core_ready_i,
  input  logic        core_idle_i,
  input  logic        core_done_i,
`ifdef LW_SHA_PADDER_ABORT_EN
  input  logic        abort_i,
  output logic        core_abort_o,
`endif
  output logic        busy_o,
  output logic        done_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, PADW, ZERO, LENH, LENL, WAIT} state_t;
  state_t           state_q, state_d, pad_next;
  logic [3:0]       idx_q, idx_d;
  logic [LEN_W-1:0] bytes_q, bytes_d;
  logic             opcode_q, opcode_d;
  logic             in_phase, pad_phase, abort, xfer;
  logic [31:0]      msg_word;
  logic [63:0]      bitlen;
  assign in_phase      = state_q == START || state_q == DATA;
  assign pad_phase     = state_q == PADW || state_q == ZERO || state_q == LENH || state_q == LENL;
  assign bitlen        = {{(64-LEN_W){1'b0}}, bytes_q} << 3;
  assign core_opcode_o = opcode_q;
  assign busy_o        = state_q != IDLE;
  // Once the 0x80 byte is out, the length words must land on indices 14/15 of a block
  assign pad_next      = idx_q == 4'd13 ? LENH : ZERO;
`ifdef LW_SHA_PADDER_ABORT_EN
  assign abort         = abort_i && busy_o;
  assign core_abort_o  = abort;
`else
  assign abort         = 1'b0;
`endif
  // The final word carries the 0x80 marker right after its last valid byte
  assign msg_word = !in_last_i           ? in_data_i :
                    in_nbytes_i == 3'd0  ? 32'h8000_0000 :
                    in_nbytes_i == 3'd1  ? {in_data_i[31:24], 24'h80_0000} :
                    in_nbytes_i == 3'd2  ? {in_data_i[31:16], 16'h8000} :
                    in_nbytes_i == 3'd3  ? {in_data_i[31:8], 8'h80} : in_data_i;
  // State, word index, byte count and captured opcode
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      bytes_q  <= '0;
      opcode_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bytes_q  <= bytes_d;
      opcode_q <= opcode_d;
    end
  end
  // Next state: message words, then marker, zero fill and the two length words
  always_comb begin
    state_d  = state_q;
    idx_d    = xfer ? idx_q + 4'd1 : idx_q;
    bytes_d  = (in_phase && xfer) ? bytes_q + LEN_W'(in_nbytes_i) : bytes_q;
    opcode_d = core_start_o ? in_opcode_i : opcode_q;
    case (state_q)
      IDLE: begin
        state_d = core_start_o ? START : IDLE;
        idx_d   = '0;
        bytes_d = '0;
      end
      START, DATA: state_d = !xfer ? state_q : !in_last_i ? DATA : in_nbytes_i == 3'd4 ? PADW : pad_next;
      PADW, ZERO:  state_d = xfer ? pad_next : state_q;
      LENH:        state_d = xfer ? LENL : LENH;
      LENL:        state_d = xfer ? WAIT : LENL;
      WAIT:        state_d = core_done_i ? IDLE : WAIT;
      default:     state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      bytes_d = '0;
    end
  end
  // Core-side handshake and word mux; stalls hold the word because it depends only on state and held inputs
  always_comb begin
    core_start_o      = state_q == IDLE && in_valid_i && core_idle_i;
    core_data_valid_o = !abort && (core_start_o || (in_phase && in_valid_i) || pad_phase);
    core_data_o       = (core_start_o || in_phase) ? msg_word :
                        state_q == PADW ? 32'h8000_0000 :
                        state_q == LENH ? bitlen[63:32] :
                        state_q == LENL ? bitlen[31:0] : '0;
    in_ready_o        = in_phase && core_ready_i && !abort;
    core_last_o       = state_q == LENH || state_q == LENL;
    done_o            = state_q == WAIT && core_done_i && !abort;
    xfer              = busy_o && core_data_valid_o && core_ready_i;
  end
endmodule

// File: tb/tb_lw_sha_padder.sv
// tb_lw_sha_padder: directed bench for lw_sha_padder with a byte-level FIPS 180-4 padding model.
module tb_lw_sha_padder;
  logic        clk_i = 1'b0;
  logic        aresetn_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        in_last_i = 1'b0;
  logic [2:0]  in_nbytes_i = '0;
  logic        in_opcode_i = 1'b0;
  logic        core_ready_i;
  logic        core_idle_i = 1'b1;
  logic        core_done_i = 1'b0;
  logic        in_ready_o, core_start_o, core_data_valid_o, core_last_o, core_opcode_o, busy_o, done_o;
  logic [31:0] core_data_o;
`ifdef LW_SHA_PADDER_ABORT_EN
  logic        abort_i = 1'b0;
  logic        core_abort_o;
`endif
  typedef struct packed {logic last; logic [31:0] data;} word_t;
  word_t       got_q[$];
  word_t       exp_q[$];
  logic [7:0]  msg_q[$];
  int          errors = 0, checks = 0, stab_err = 0, rdy_viol = 0;
  bit          bp_en = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  lw_sha_padder dut (
    .clk_i(clk_i), .aresetn_i(aresetn_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_last_i(in_last_i),
    .in_nbytes_i(in_nbytes_i), .in_opcode_i(in_opcode_i), .in_ready_o(in_ready_o),
    .core_start_o(core_start_o), .core_data_valid_o(core_data_valid_o), .core_last_o(core_last_o),
    .core_data_o(core_data_o), .core_opcode_o(core_opcode_o),
    .core_ready_i(core_ready_i), .core_idle_i(core_idle_i), .core_done_i(core_done_i),
`ifdef LW_SHA_PADDER_ABORT_EN
    .abort_i(abort_i), .core_abort_o(core_abort_o),
`endif
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    core_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      core_ready_i = bp_en ? ~core_ready_i : 1'b1;
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (aresetn_i) begin
      if (in_ready_o && !core_ready_i) rdy_viol++;
      if (prev_stall && core_data_valid_o && core_data_o !== prev_data) stab_err++;
      if (core_data_valid_o && !core_start_o && core_ready_i) got_q.push_back({core_last_o, core_data_o});
      prev_stall = core_data_valid_o && !core_start_o && !core_ready_i;
      prev_data  = core_data_o;
    end else prev_stall = 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] n, input logic last, input logic op);
    bit ok = 0;
    in_valid_i = 1'b1; in_data_i = d; in_nbytes_i = n; in_last_i = last; in_opcode_i = op;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk_i);
      ok = in_ready_o;
    end
    chk("send_accept", 64'(ok), 64'd1);
    for (int k = 0; k < int'(n); k++) msg_q.push_back(d[31-8*k -: 8]);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0; in_last_i = 1'b0;
  endtask

  task automatic wait_words(input int n, input string tag);
    bit ok = 0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(posedge clk_i);
      #2;
      ok = got_q.size() >= n;
    end
    chk({tag, "_timeout"}, 64'(ok), 64'd1);
  endtask

  task automatic check_stream(input string tag);
    logic [7:0]  b[$];
    logic [63:0] bl;
    int          nw;
    word_t       g;
    b  = msg_q;
    bl = 64'(msg_q.size()) * 64'd8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int i = 7; i >= 0; i--) b.push_back(bl[8*i +: 8]);
    nw = b.size() / 4;
    exp_q.delete();
    for (int i = 0; i < nw; i++) exp_q.push_back({(i >= nw - 2), b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]});
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < nw; i++) begin
      g = i < got_q.size() ? got_q[i] : '0;
      chk($sformatf("%s_w%0d", tag, i), 64'(g), 64'(exp_q[i]));
    end
  endtask

  task automatic finish_msg(input string tag);
    @(negedge clk_i);
    chk({tag, "_busy_wait"}, 64'(busy_o), 64'd1);
    chk({tag, "_no_early_done"}, 64'(done_o), 64'd0);
    core_done_i = 1'b1;
    #1;
    chk({tag, "_done"}, 64'(done_o), 64'd1);
    @(posedge clk_i);
    #1;
    core_done_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    chk({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  task automatic new_msg();
    got_q.delete();
    msg_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_in_ready", 64'(in_ready_o), 0);
    chk("rst_start", 64'(core_start_o), 0);
    chk("rst_valid", 64'(core_data_valid_o), 0);
    chk("rst_last", 64'(core_last_o), 0);
    chk("rst_data", 64'(core_data_o), 0);
    chk("rst_opcode", 64'(core_opcode_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_done", 64'(done_o), 0);
    @(posedge clk_i);
    #1;
    aresetn_i = 1'b1;

    new_msg();
    send(32'h6162_6300, 3'd3, 1'b1, 1'b0);
    wait_words(16, "abc");
    check_stream("abc");
    chk("abc_w0", 64'(got_q[0]), 64'({1'b0, 32'h6162_6380}));
    chk("abc_w14", 64'(got_q[14]), 64'({1'b1, 32'h0}));
    chk("abc_w15", 64'(got_q[15]), 64'({1'b1, 32'h18}));
    chk("abc_opcode", 64'(core_opcode_o), 0);
    finish_msg("abc");

    new_msg();
    send(32'hDEAD_BEEF, 3'd0, 1'b1, 1'b1);
    wait_words(16, "empty");
    check_stream("empty");
    chk("empty_w0", 64'(got_q[0]), 64'({1'b0, 32'h8000_0000}));
    chk("empty_w15", 64'(got_q[15]), 64'({1'b1, 32'h0}));
    chk("empty_opcode", 64'(core_opcode_o), 1);
    finish_msg("empty");

    new_msg();
    for (int i = 0; i < 14; i++) send(32'h0123_4567 ^ (32'(i) * 32'h0101_0101), 3'd4, i == 13, 1'b0);
    wait_words(32, "m56");
    check_stream("m56");
    chk("m56_w14", 64'(got_q[14]), 64'({1'b0, 32'h8000_0000}));
    chk("m56_w15", 64'(got_q[15]), 64'({1'b0, 32'h0}));
    chk("m56_w31", 64'(got_q[31]), 64'({1'b1, 32'h1C0}));
    chk("m56_opcode", 64'(core_opcode_o), 0);
    finish_msg("m56");

    new_msg();
    bp_en = 1;
    for (int i = 0; i < 13; i++) send(32'hA5A5_0000 + 32'(i), 3'd4, 1'b0, 1'b0);
    send(32'hAABB_CC00, 3'd3, 1'b1, 1'b0);
    wait_words(16, "m55");
    check_stream("m55");
    chk("m55_w13", 64'(got_q[13]), 64'({1'b0, 32'hAABB_CC80}));
    chk("m55_w15", 64'(got_q[15]), 64'({1'b1, 32'h1B8}));
    finish_msg("m55");

    new_msg();
    send(32'h6162_6300, 3'd3, 1'b1, 1'b0);
    wait_words(16, "abc_bp");
    check_stream("abc_bp");
    finish_msg("abc_bp");
    bp_en = 0;
    repeat (2) @(posedge clk_i);
    chk("bp_stable", 64'(stab_err), 0);
    chk("bp_ready_gate", 64'(rdy_viol), 0);

    new_msg();
    for (int i = 0; i < 3; i++) send(32'h1111_1111 * 32'(i + 1), 3'd4, 1'b0, 1'b0);
    aresetn_i = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_o), 0);
    chk("midrst_valid", 64'(core_data_valid_o), 0);
    #3;
    aresetn_i = 1'b1;
    @(posedge clk_i);
    #1;

`ifdef LW_SHA_PADDER_ABORT_EN
    new_msg();
    for (int i = 0; i < 7; i++) send(32'h7700_0000 + 32'(i), 3'd4, 1'b0, 1'b0);
    abort_i = 1'b1;
    @(negedge clk_i);
    chk("abort_pulse", 64'(core_abort_o), 1);
    chk("abort_no_done", 64'(done_o), 0);
    chk("abort_in_ready", 64'(in_ready_o), 0);
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    @(negedge clk_i);
    chk("abort_idle", 64'(busy_o), 0);
    chk("abort_pulse_end", 64'(core_abort_o), 0);
    chk("abort_done_low", 64'(done_o), 0);
    new_msg();
    send(32'h6162_6300, 3'd3, 1'b1, 1'b0);
    wait_words(16, "abc_after_abort");
    check_stream("abc_after_abort");
    finish_msg("abc_after_abort");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
